// File: rtl/pet_bus_pkg.sv
// Shared bus widths, owner encodings, default slot timing and window-phase decode.
package pet_bus_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_PI  = 1'b1;

    localparam int DEF_CYCLE_LEN = 16;
    localparam int DEF_CPU_START = 0;
    localparam int DEF_PI_START  = 8;
    localparam int DEF_WIN_LEN   = 4;

    // Where a slot counter value falls inside a window
    typedef enum logic [1:0] {
        PH_IDLE,    // outside the window
        PH_SETUP,   // k = 0: address/data launch
        PH_STROBE,  // k = 1..len-2: we_n or oe_n active
        PH_LAST     // k = len-1: strobes off, completion
    } phase_e;

    // Latched Pi command
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw_b;
    } bus_req_t;

    function automatic phase_e win_phase(input int cnt, input int start, input int len);
        if (cnt < start || cnt >= start + len) return PH_IDLE;
        if (cnt == start)                      return PH_SETUP;
        if (cnt == start + len - 1)            return PH_LAST;
        return PH_STROBE;
    endfunction

endpackage

// File: rtl/pi_bus_arbiter_sync_rise.sv
// Two-flop synchroniser followed by a one-clock rising-edge pulse.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    // sh[0], sh[1] form the synchroniser; sh[2] is the edge-detect history
    logic [2:0] sh;

    // Shift the asynchronous level through the synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sh <= '0;
        else       sh <= {sh[1:0], d};
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/pi_bus_arbiter.sv
// Time-slot arbiter sharing the system RAM/IO bus between the CPU and the Pi command register.
module pi_bus_arbiter
    import pet_bus_pkg::*;
#(
    parameter int CYCLE_LEN = DEF_CYCLE_LEN,
    parameter int CPU_START = DEF_CPU_START,
    parameter int PI_START  = DEF_PI_START,
    parameter int WIN_LEN   = DEF_WIN_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pi_pending,
    input  logic [ADDR_W-1:0] pi_addr,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_rw_b,
    output logic [DATA_W-1:0] pi_rd_data,
    output logic              pi_done,
    output logic              pi_overrun,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_rw_b,
    output logic              cpu_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_out,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              bus_we_n,
    output logic              bus_oe_n,
    output logic              bus_owner
);

    localparam int CNT_W = $clog2(CYCLE_LEN);

    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pend_rise;
    logic              req;
    bus_req_t          pi_q;
    logic              pi_act, pi_act_nxt;
    phase_e            cpu_ph, pi_ph;

    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] dout_nxt, rd_nxt;
    logic              we_n_nxt, oe_n_nxt, owner_nxt, cpu_en_nxt, done_nxt;

    sync_rise u_pend_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pi_pending),
        .rise  (pend_rise)
    );

    // Slot counter lookahead; outputs are registered from the slot about to start
    always_comb begin
        cnt_nxt = (cnt == CNT_W'(CYCLE_LEN - 1)) ? '0 : cnt + 1'b1;
        cpu_ph  = win_phase(int'(cnt_nxt), CPU_START, WIN_LEN);
        pi_ph   = win_phase(int'(cnt_nxt), PI_START, WIN_LEN);
    end

    // Pi grant is decided entering the Pi window (req as seen at PI_START-1) and held through it
    always_comb begin
        pi_act_nxt = pi_act;
        if (pi_ph == PH_SETUP)     pi_act_nxt = req;
        else if (pi_ph == PH_IDLE) pi_act_nxt = 1'b0;
    end

    // Next-state bus outputs for the upcoming slot
    always_comb begin
        addr_nxt   = bus_addr;
        dout_nxt   = bus_data_out;
        rd_nxt     = pi_rd_data;
        we_n_nxt   = 1'b1;
        oe_n_nxt   = 1'b1;
        owner_nxt  = OWNER_CPU;
        cpu_en_nxt = 1'b0;
        done_nxt   = 1'b0;
        if (cpu_ph != PH_IDLE) begin
            owner_nxt = OWNER_CPU;
            case (cpu_ph)
                PH_SETUP: begin
                    addr_nxt = cpu_addr;
                    dout_nxt = cpu_data;
                end
                PH_STROBE: begin
                    if (cpu_rw_b) oe_n_nxt = 1'b0;
                    else          we_n_nxt = 1'b0;
                end
                PH_LAST:  cpu_en_nxt = 1'b1;
                default:  ;
            endcase
        end else if (pi_ph != PH_IDLE && pi_act_nxt) begin
            owner_nxt = OWNER_PI;
            case (pi_ph)
                PH_SETUP: begin
                    addr_nxt = pi_q.addr;
                    dout_nxt = pi_q.data;
                end
                PH_STROBE: begin
                    if (pi_q.rw_b) oe_n_nxt = 1'b0;
                    else           we_n_nxt = 1'b0;
                end
                PH_LAST: begin
                    done_nxt = 1'b1;
                    if (pi_q.rw_b) rd_nxt = bus_data_in;
                end
                default: ;
            endcase
        end
    end

    // Slot counter and grant flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pi_act <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            pi_act <= pi_act_nxt;
        end
    end

    // Request latch: accept a new command only when idle, otherwise flag overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req        <= 1'b0;
            pi_q       <= '0;
            pi_overrun <= 1'b0;
        end else begin
            if (pend_rise && req) pi_overrun <= 1'b1;
            if (done_nxt) begin
                req <= 1'b0;
            end else if (pend_rise && !req) begin
                req       <= 1'b1;
                pi_q.addr <= pi_addr;
                pi_q.data <= pi_data;
                pi_q.rw_b <= pi_rw_b;
            end
        end
    end

    // Registered bus and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr     <= '0;
            bus_data_out <= '0;
            bus_we_n     <= 1'b1;
            bus_oe_n     <= 1'b1;
            bus_owner    <= OWNER_CPU;
            cpu_en       <= 1'b0;
            pi_done      <= 1'b0;
            pi_rd_data   <= '0;
        end else begin
            bus_addr     <= addr_nxt;
            bus_data_out <= dout_nxt;
            bus_we_n     <= we_n_nxt;
            bus_oe_n     <= oe_n_nxt;
            bus_owner    <= owner_nxt;
            cpu_en       <= cpu_en_nxt;
            pi_done      <= done_nxt;
            pi_rd_data   <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_pi_bus_arbiter.sv
// Directed bench for pi_bus_arbiter; cyc counts clk edges since reset release, slot = cyc % 16.
module tb_pi_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pi_pending;
    logic [16:0] pi_addr;
    logic [7:0]  pi_data;
    logic        pi_rw_b;
    logic [7:0]  pi_rd_data;
    logic        pi_done;
    logic        pi_overrun;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw_b;
    logic        cpu_en;
    logic [16:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_we_n;
    logic        bus_oe_n;
    logic        bus_owner;

    int cyc;
    int n_chk;
    int n_pass;
    int ndone;

    pi_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .pi_pending   (pi_pending),
        .pi_addr      (pi_addr),
        .pi_data      (pi_data),
        .pi_rw_b      (pi_rw_b),
        .pi_rd_data   (pi_rd_data),
        .pi_done      (pi_done),
        .pi_overrun   (pi_overrun),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_rw_b     (cpu_rw_b),
        .cpu_en       (cpu_en),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .bus_we_n     (bus_we_n),
        .bus_oe_n     (bus_oe_n),
        .bus_owner    (bus_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    // One clock: cross the edge, then park on the falling edge to sample/drive
    task automatic adv();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) adv();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset       = 1'b1;
        pi_pending  = 1'b0;
        pi_addr     = '0;
        pi_data     = '0;
        pi_rw_b     = 1'b0;
        cpu_addr    = 17'h00123;
        cpu_data    = 8'hA5;
        cpu_rw_b    = 1'b1;
        bus_data_in = 8'hC3;
        cyc = 0; n_chk = 0; n_pass = 0; ndone = 0;

        do_reset();
        chk("rst_we_n",  32'(bus_we_n),     32'd1);
        chk("rst_oe_n",  32'(bus_oe_n),     32'd1);
        chk("rst_owner", 32'(bus_owner),    32'd0);
        chk("rst_addr",  32'(bus_addr),     32'd0);
        chk("rst_dout",  32'(bus_data_out), 32'd0);
        chk("rst_cpuen", 32'(cpu_en),       32'd0);
        chk("rst_done",  32'(pi_done),      32'd0);
        chk("rst_ovr",   32'(pi_overrun),   32'd0);
        chk("rst_rd",    32'(pi_rd_data),   32'd0);

        // 1: CPU-only cycles, CPU reads
        for (int c = 0; c <= 33; c++) begin
            run_to(c);
            chk("t1_cpuen", 32'(cpu_en),    32'((c % 16) == 3));
            chk("t1_owner", 32'(bus_owner), 32'd0);
            chk("t1_oe_n",  32'(bus_oe_n),  32'(!((c % 16) == 1 || (c % 16) == 2)));
            chk("t1_we_n",  32'(bus_we_n),  32'd1);
            if (c == 17) chk("t1_addr", 32'(bus_addr), 32'h00123);
        end

        // 2: Pi write, pending rises at slot 2
        run_to(34);
        pi_addr = 17'h08000; pi_data = 8'h5A; pi_rw_b = 1'b0; pi_pending = 1'b1;
        run_to(40);
        chk("t2_addr",  32'(bus_addr),     32'h08000);
        chk("t2_dout",  32'(bus_data_out), 32'h5A);
        chk("t2_owner", 32'(bus_owner),    32'd1);
        chk("t2_we8",   32'(bus_we_n),     32'd1);
        run_to(41);
        chk("t2_we9",   32'(bus_we_n),     32'd0);
        chk("t2_oe9",   32'(bus_oe_n),     32'd1);
        run_to(42);
        chk("t2_we10",  32'(bus_we_n),     32'd0);
        chk("t2_done10",32'(pi_done),      32'd0);
        run_to(43);
        chk("t2_we11",  32'(bus_we_n),     32'd1);
        chk("t2_done11",32'(pi_done),      32'd1);
        chk("t2_own11", 32'(bus_owner),    32'd1);
        run_to(44);
        chk("t2_done12",32'(pi_done),      32'd0);
        chk("t2_own12", 32'(bus_owner),    32'd0);
        pi_pending = 1'b0;

        // 3: Pi read
        run_to(50);
        pi_addr = 17'h1E810; pi_rw_b = 1'b1; pi_pending = 1'b1;
        run_to(56);
        chk("t3_addr",  32'(bus_addr),   32'h1E810);
        chk("t3_owner", 32'(bus_owner),  32'd1);
        chk("t3_oe8",   32'(bus_oe_n),   32'd1);
        run_to(57);
        chk("t3_oe9",   32'(bus_oe_n),   32'd0);
        chk("t3_we9",   32'(bus_we_n),   32'd1);
        run_to(58);
        chk("t3_oe10",  32'(bus_oe_n),   32'd0);
        chk("t3_rd10",  32'(pi_rd_data), 32'h00);
        run_to(59);
        chk("t3_oe11",  32'(bus_oe_n),   32'd1);
        chk("t3_done",  32'(pi_done),    32'd1);
        chk("t3_rd11",  32'(pi_rd_data), 32'hC3);
        run_to(60);
        chk("t3_done12",32'(pi_done),    32'd0);
        chk("t3_rdhold",32'(pi_rd_data), 32'hC3);
        pi_pending = 1'b0;

        // 4: req lands at slot 8, one full cycle late
        run_to(69);
        pi_addr = 17'h0AAAA; pi_data = 8'h11; pi_rw_b = 1'b0; pi_pending = 1'b1;
        run_to(72);
        chk("t4_own8",  32'(bus_owner), 32'd0);
        run_to(73);
        chk("t4_we9",   32'(bus_we_n),  32'd1);
        run_to(75);
        chk("t4_done11",32'(pi_done),   32'd0);
        pi_pending = 1'b0;
        run_to(88);
        chk("t4_addr",  32'(bus_addr),     32'h0AAAA);
        chk("t4_dout",  32'(bus_data_out), 32'h11);
        chk("t4_own24", 32'(bus_owner),    32'd1);
        run_to(89);
        chk("t4_we25",  32'(bus_we_n),  32'd0);
        run_to(91);
        chk("t4_done27",32'(pi_done),   32'd1);
        run_to(92);
        chk("t4_done28",32'(pi_done),   32'd0);

        // 5: second rise while queued -> overrun, single service with first address
        run_to(97);
        pi_addr = 17'h03333; pi_data = 8'h44; pi_rw_b = 1'b0; pi_pending = 1'b1;
        run_to(100);
        pi_pending = 1'b0;
        run_to(101);
        chk("t5_ovr0",  32'(pi_overrun), 32'd0);
        pi_addr = 17'h01111; pi_data = 8'h22;
        run_to(102);
        pi_pending = 1'b1;
        run_to(104);
        chk("t5_addr",  32'(bus_addr),     32'h03333);
        chk("t5_dout",  32'(bus_data_out), 32'h44);
        chk("t5_owner", 32'(bus_owner),    32'd1);
        ndone = int'(pi_done);
        run_to(105);
        chk("t5_ovr1",  32'(pi_overrun), 32'd1);
        ndone += int'(pi_done);
        for (int c = 106; c <= 140; c++) begin
            run_to(c);
            if (c == 106) pi_pending = 1'b0;
            ndone += int'(pi_done);
        end
        chk("t5_ndone", 32'(ndone),      32'd1);
        chk("t5_sticky",32'(pi_overrun), 32'd1);

        // 6: reset in the middle of a Pi write
        run_to(146);
        pi_addr = 17'h05555; pi_data = 8'h66; pi_rw_b = 1'b0; pi_pending = 1'b1;
        run_to(152);
        chk("t6_own8",  32'(bus_owner), 32'd1);
        run_to(153);
        chk("t6_we9",   32'(bus_we_n),  32'd0);
        #1;
        reset = 1'b1;
        pi_pending = 1'b0;
        #1;
        chk("t6_we_rst",  32'(bus_we_n),  32'd1);
        chk("t6_own_rst", 32'(bus_owner), 32'd0);
        chk("t6_addr_rst",32'(bus_addr),  32'd0);
        do_reset();
        ndone = 0;
        for (int c = 0; c <= 20; c++) begin
            run_to(c);
            ndone += int'(pi_done);
            if (c == 2 || c == 3) chk("t6_cpuen", 32'(cpu_en), 32'(c == 3));
        end
        chk("t6_ndone", 32'(ndone),      32'd0);
        chk("t6_ovr",   32'(pi_overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
